// File: rtl/field_source_gen_if.sv
// Field-source bus: start/gravity request, field RAM write port and renderer handshake.
interface field_source_gen_if #(
  parameter int unsigned FIELD_ADDRW = 6,
  parameter int unsigned FIELD_DATAW = 96
) ();
  logic                   start;
  logic signed [15:0]     gx;
  logic signed [15:0]     gy;
  logic                   field_we;
  logic [FIELD_ADDRW-1:0] field_addr;
  logic [FIELD_DATAW-1:0] field_data;
  logic                   draw_start;
  logic                   draw_done;
  logic                   busy;
  logic                   done;
  logic                   timeout_err;

  modport master (
    input  start, gx, gy, draw_done,
    output field_we, field_addr, field_data, draw_start, busy, done, timeout_err
  );

  modport slave (
    output start, gx, gy, draw_done,
    input  field_we, field_addr, field_data, draw_start, busy, done, timeout_err
  );
endinterface

// File: rtl/field_source_gen.sv
// Fills the vector-field RAM from a latched gravity sample plus a swirl about
// the field centre, then kicks the renderer and waits (bounded) for it.
module field_source_gen #(
  parameter int unsigned FIELD_WIDTH  = 8,
  parameter int unsigned FIELD_HEIGHT = 6,
  parameter int          SWIRL        = 16,
  parameter int unsigned TIMEOUT      = 1048576
) (
  input logic                clk,
  input logic                rst_n,
  field_source_gen_if.master bus
);
  localparam int unsigned FIELD_SIZE  = FIELD_WIDTH * FIELD_HEIGHT;
  localparam int unsigned FIELD_ADDRW = $clog2(FIELD_SIZE);
  localparam int unsigned FIELD_DATAW = 96;
  localparam int unsigned COLW  = (FIELD_WIDTH  > 1) ? $clog2(FIELD_WIDTH)  : 1;
  localparam int unsigned ROWW  = (FIELD_HEIGHT > 1) ? $clog2(FIELD_HEIGHT) : 1;
  localparam int unsigned WAITW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int          HALF_W = int'(FIELD_WIDTH / 2);
  localparam int          HALF_H = int'(FIELD_HEIGHT / 2);

  typedef enum logic [2:0] {IDLE, FILL, DRAIN, KICK, WAIT} state_t;

  state_t             state, state_next;
  logic [ROWW-1:0]    row, row_next;
  logic [COLW-1:0]    col, col_next;
  logic               drain_cnt, drain_next;
  logic [WAITW-1:0]   wait_cnt, wait_next;
  logic signed [15:0] gx_q, gx_next, gy_q, gy_next;
  logic               err_q, err_next;
  logic               done_next;
  logic               fill_valid_c;

  logic               s1_valid;
  logic [FIELD_ADDRW-1:0] s1_addr;
  logic signed [31:0] s1_xn, s1_yn;

  logic               we_q, draw_start_q, busy_q, done_q;
  logic [FIELD_ADDRW-1:0] addr_q;
  logic [FIELD_DATAW-1:0] data_q;

  // State, counters and registered control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      drain_cnt    <= 1'b0;
      wait_cnt     <= '0;
      gx_q         <= '0;
      gy_q         <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      draw_start_q <= 1'b0;
    end else begin
      state        <= state_next;
      row          <= row_next;
      col          <= col_next;
      drain_cnt    <= drain_next;
      wait_cnt     <= wait_next;
      gx_q         <= gx_next;
      gy_q         <= gy_next;
      err_q        <= err_next;
      done_q       <= done_next;
      busy_q       <= (state_next != IDLE);
      draw_start_q <= (state_next == KICK);
    end
  end

  // Next-state: address sweep, drain, renderer kick and bounded wait
  always_comb begin
    state_next   = state;
    row_next     = row;
    col_next     = col;
    drain_next   = drain_cnt;
    wait_next    = wait_cnt;
    gx_next      = gx_q;
    gy_next      = gy_q;
    err_next     = err_q;
    done_next    = 1'b0;
    fill_valid_c = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          gx_next    = bus.gx;
          gy_next    = bus.gy;
          err_next   = 1'b0;
          row_next   = '0;
          col_next   = '0;
          state_next = FILL;
        end
      end
      FILL: begin
        fill_valid_c = 1'b1;
        if (col == COLW'(FIELD_WIDTH - 1)) begin
          col_next = '0;
          if (row == ROWW'(FIELD_HEIGHT - 1)) begin
            row_next   = '0;
            drain_next = 1'b0;
            state_next = DRAIN;
          end else begin
            row_next = row + 1'b1;
          end
        end else begin
          col_next = col + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt) state_next = KICK;
        else           drain_next = 1'b1;
      end
      KICK: begin
        wait_next  = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (bus.draw_done) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (wait_cnt == WAITW'(TIMEOUT - 1)) begin
          done_next  = 1'b1;
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          wait_next = wait_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage 1: cell vector = gravity + swirl offset about the centre
  logic signed [31:0] row_off_c, col_off_c;
  assign row_off_c = $signed(32'(row)) - HALF_H;
  assign col_off_c = $signed(32'(col)) - HALF_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_xn    <= '0;
      s1_yn    <= '0;
    end else begin
      s1_valid <= fill_valid_c;
      if (fill_valid_c) begin
        s1_addr <= FIELD_ADDRW'(32'(row) * FIELD_WIDTH + 32'(col));
        s1_xn   <= 32'(gx_q) - row_off_c * SWIRL;
        s1_yn   <= 32'(gy_q) + col_off_c * SWIRL;
      end
    end
  end

  // Stage 2: saturated L1 magnitude and RAM write
  logic [31:0] abs_x_c, abs_y_c, mag_c;
  logic [32:0] sum_c;
  assign abs_x_c = s1_xn[31] ? 32'(-s1_xn) : 32'(s1_xn);
  assign abs_y_c = s1_yn[31] ? 32'(-s1_yn) : 32'(s1_yn);
  assign sum_c   = 33'(abs_x_c) + 33'(abs_y_c);
  assign mag_c   = (sum_c > 33'h07FFFFFFF) ? 32'h7FFFFFFF : sum_c[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= s1_valid;
      if (s1_valid) begin
        addr_q <= s1_addr;
        data_q <= {s1_xn, s1_yn, mag_c};
      end
    end
  end

  assign bus.field_we    = we_q;
  assign bus.field_addr  = addr_q;
  assign bus.field_data  = data_q;
  assign bus.draw_start  = draw_start_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_field_source_gen.sv
// Directed bench for field_source_gen: vector table of cell values plus
// hand-written pass, busy-filter, timeout and mid-pass reset sequences.
module tb_field_source_gen;
  logic clk;
  logic rst_n;

  field_source_gen_if bus ();

  field_source_gen #(
    .FIELD_WIDTH (8),
    .FIELD_HEIGHT(6),
    .SWIRL       (16),
    .TIMEOUT     (100)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int     gx;
    int     gy;
    int     addr;
    longint xn;
    longint yn;
    longint mag;
  } vec_t;

  int n_cmp;
  int n_fail;

  // Per-pass observations
  longint cap_x [48];
  longint cap_y [48];
  longint cap_m [48];
  int we_cnt, first_we, last_we, order_ok;
  int ds_cnt, ds_cyc, done_cyc, err_c1, err_done, busy_after, done_after;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One start..done pass; cycle c is observed #1 after edge c-1, start sampled at edge 0
  task automatic run_pass(input logic signed [15:0] g_x, input logic signed [15:0] g_y,
                          input int dd_cyc, input bit noisy);
    int cyc;
    we_cnt = 0; first_we = -1; last_we = -1; order_ok = 1;
    ds_cnt = 0; ds_cyc = -1; done_cyc = -1; err_c1 = -1; err_done = -1;
    bus.gx = g_x;
    bus.gy = g_y;
    bus.start = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    if (!noisy) bus.start = 1'b0;
    while (cyc <= 220 && done_cyc < 0) begin
      if (cyc == 1) err_c1 = int'(bus.timeout_err);
      if (bus.field_we) begin
        if (first_we < 0) first_we = cyc;
        last_we = cyc;
        if (int'(bus.field_addr) != we_cnt) order_ok = 0;
        if (we_cnt < 48) begin
          cap_x[we_cnt] = longint'($signed(bus.field_data[95:64]));
          cap_y[we_cnt] = longint'($signed(bus.field_data[63:32]));
          cap_m[we_cnt] = longint'($signed(bus.field_data[31:0]));
        end
        we_cnt++;
      end
      if (bus.draw_start) begin
        ds_cnt++;
        ds_cyc = cyc;
      end
      if (bus.done) begin
        done_cyc = cyc;
        err_done = int'(bus.timeout_err);
      end
      bus.draw_done = (cyc == dd_cyc) || (noisy && (cyc == 10 || cyc == 51));
      if (noisy) begin
        bus.start = (cyc < 30);
        bus.gx = ~bus.gx;
      end
      if (done_cyc < 0) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    bus.draw_done = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    busy_after = int'(bus.busy);
    done_after = int'(bus.done);
  endtask

  vec_t vecs [8];

  initial begin
    int ds_seen;
    int we_seen;
    int busy_seen;
    n_cmp = 0;
    n_fail = 0;
    vecs[0] = '{100, -50, 0, 148, -114, 262};
    vecs[1] = '{100, -50, 47, 68, -2, 70};
    vecs[2] = '{100, -50, 27, 100, -66, 166};
    vecs[3] = '{-32768, -32768, 0, -32720, -32832, 65552};
    vecs[4] = '{-32768, -32768, 47, -32800, -32720, 65520};
    vecs[5] = '{32767, 32767, 0, 32815, 32703, 65518};
    vecs[6] = '{32767, 32767, 47, 32735, 32815, 65550};
    vecs[7] = '{0, 0, 20, 16, 0, 16};

    // Reset then idle
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.gx = '0;
    bus.gy = '0;
    bus.draw_done = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_field_we", longint'(bus.field_we), 0);
    check("rst_field_addr", longint'(bus.field_addr), 0);
    check("rst_field_data_or", longint'(|bus.field_data), 0);
    check("rst_draw_start", longint'(bus.draw_start), 0);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_done", longint'(bus.done), 0);
    check("rst_timeout_err", longint'(bus.timeout_err), 0);
    rst_n = 1'b1;
    busy_seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      busy_seen += int'(bus.busy | bus.field_we | bus.draw_start | bus.done);
    end
    check("idle_quiet", busy_seen, 0);

    // Single pass timing
    run_pass(16'sd100, -16'sd50, 60, 1'b0);
    check("pass_we_count", we_cnt, 48);
    check("pass_first_we_cycle", first_we, 3);
    check("pass_last_we_cycle", last_we, 50);
    check("pass_addr_ascending", order_ok, 1);
    check("pass_draw_start_count", ds_cnt, 1);
    check("pass_draw_start_cycle", ds_cyc, 51);
    check("pass_done_cycle", done_cyc, 61);
    check("pass_err_at_done", err_done, 0);
    check("pass_busy_after", busy_after, 0);
    check("pass_done_single", done_after, 0);

    // Cell value table
    for (int i = 0; i < 8; i++) begin
      run_pass(16'(vecs[i].gx), 16'(vecs[i].gy), 60, 1'b0);
      check($sformatf("vec%0d_xn", i), cap_x[vecs[i].addr], vecs[i].xn);
      check($sformatf("vec%0d_yn", i), cap_y[vecs[i].addr], vecs[i].yn);
      check($sformatf("vec%0d_mag", i), cap_m[vecs[i].addr], vecs[i].mag);
    end

    // Busy filtering: start held, gx toggling, spurious draw_done in FILL and KICK
    run_pass(16'sd100, -16'sd50, 70, 1'b1);
    check("noisy_we_count", we_cnt, 48);
    check("noisy_draw_start_count", ds_cnt, 1);
    check("noisy_done_cycle", done_cyc, 71);
    check("noisy_xn0", cap_x[0], 148);
    check("noisy_yn47", cap_y[47], -2);
    check("noisy_busy_after", busy_after, 0);

    // Timeout: no draw_done
    run_pass(16'sd5, 16'sd5, -1, 1'b0);
    check("to_draw_start_cycle", ds_cyc, 51);
    check("to_done_cycle", done_cyc, 152);
    check("to_err_at_done", err_done, 1);
    repeat (3) @(posedge clk);
    #1;
    check("to_err_sticky", longint'(bus.timeout_err), 1);
    run_pass(16'sd100, -16'sd50, 60, 1'b0);
    check("to_err_cleared_on_start", err_c1, 0);
    check("to_next_done_cycle", done_cyc, 61);
    check("to_next_err_at_done", err_done, 0);

    // Reset mid-FILL
    bus.gx = 16'sd100;
    bus.gy = -16'sd50;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) begin
      @(posedge clk); #1;
    end
    check("midrst_we_before", longint'(bus.field_we), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_we_drop", longint'(bus.field_we), 0);
    check("midrst_busy_drop", longint'(bus.busy), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ds_seen = 0;
    we_seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      ds_seen += int'(bus.draw_start);
      we_seen += int'(bus.field_we);
    end
    check("midrst_no_draw_start", ds_seen, 0);
    check("midrst_no_writes", we_seen, 0);
    run_pass(16'sd100, -16'sd50, 60, 1'b0);
    check("midrst_re_we_count", we_cnt, 48);
    check("midrst_re_first_we", first_we, 3);
    check("midrst_re_order", order_ok, 1);
    check("midrst_re_xn0", cap_x[0], 148);
    check("midrst_re_done_cycle", done_cyc, 61);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/field_source_gen.md
Name: field_source_gen

Overview:
- Upstream producer for the block renderer: fills the FIELD_WIDTH x FIELD_HEIGHT vector-field RAM, then kicks the renderer and waits for it to finish.
- Each cell gets a vector built from a latched gravity sample (gx, gy) plus a fixed swirl offset about the field centre, and that vector's L1 magnitude.
- Entry format matches the renderer's field port: {xn, yn, mag}, each 32-bit signed, row-major addressing.

Parameters:
- FIELD_WIDTH, 8, cells per row.
- FIELD_HEIGHT, 6, rows.
- FIELD_SIZE, FIELD_WIDTH*FIELD_HEIGHT, total cells.
- FIELD_ADDRW, $clog2(FIELD_SIZE), field address width.
- FIELD_DATAW, 96, entry width; fixed at 3x32.
- SWIRL, 16, swirl offset per cell of distance from centre.
- TIMEOUT, 1048576, maximum cycles spent waiting for draw_done.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request one fill+draw pass; sampled only in IDLE.
- gx  in  16  signed gravity x; latched on the accepted start.
- gy  in  16  signed gravity y; latched on the accepted start.
- field_we  out  1  field RAM write enable.
- field_addr  out  FIELD_ADDRW  field RAM write address.
- field_data  out  FIELD_DATAW  {xn[95:64], yn[63:32], mag[31:0]}.
- draw_start  out  1  single-cycle kick to the renderer.
- draw_done  in  1  renderer-finished pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pass-complete pulse.
- timeout_err  out  1  sticky flag; set on wait timeout, cleared by the next accepted start.

Behaviour:
- Reset (async, rst_n=0): state IDLE, all outputs 0, counters 0, latched gx/gy 0. Deasserting rst_n mid-pass abandons the pass; no partial draw_start is issued.
- FSM states:
  - IDLE -> FILL on start=1: latch gx, gy; clear timeout_err; row=col=0.
  - FILL: generates one address per cycle for FIELD_SIZE cycles. col increments fastest; at col=FIELD_WIDTH-1, col wraps to 0 and row increments. Last address -> DRAIN.
  - DRAIN: 2 cycles to flush the pipeline -> KICK.
  - KICK: draw_start=1 for exactly 1 cycle -> WAIT; wait counter cleared.
  - WAIT: on draw_done=1 -> IDLE with done=1. If the counter reaches TIMEOUT-1 without draw_done -> IDLE with done=1 and timeout_err=1.
- draw_done is sampled only in WAIT; pulses in any other state are ignored. start is ignored while busy.
- Pipeline: 2 registered stages; 1 write per cycle; 2 cycles from address generation to the field_we output.
- Stage 1 (cell vector):
  - addr = row*FIELD_WIDTH + col.
  - xn = sext32(gx) - (row - FIELD_HEIGHT/2)*SWIRL.
  - yn = sext32(gy) + (col - FIELD_WIDTH/2)*SWIRL.
  - Arithmetic is 32-bit signed; row/col are zero-extended before subtraction.
- Stage 2 (magnitude and write): mag = |xn| + |yn|, saturated to 0x7FFFFFFF. Register field_addr, field_data and field_we=1.
- field_we is 0 whenever no valid pipeline entry is present.
- Timing, with start sampled at edge 0:
  - FILL occupies cycles 1..FIELD_SIZE.
  - field_we is high in cycles 3..FIELD_SIZE+2 (contiguous, addresses ascending 0..FIELD_SIZE-1).
  - draw_start fires in cycle FIELD_SIZE+3.
- gx/gy changes after the accepted start have no effect on the current pass.

Test Plan:
- Reset then idle: rst_n low 5 cycles, then high; no stimulus -> all outputs 0; busy=0 indefinitely.
- Single pass, gx=100, gy=-50, defaults: start pulse at cycle 0 -> field_we high cycles 3..50, addresses 0..47 ascending. addr 0 = {148, -114, 262}; addr 47 = {68, -2, 70}; addr 27 (row3,col3) = {100, -66, 166}. draw_start=1 only at cycle 51. draw_done at cycle 60 -> done=1 at cycle 61, busy=0 after.
- Negative extremes: gx=-32768, gy=-32768 -> addr 0 = {-32720, -32832, 65552}; all xn/yn sign-extended correctly.
- Busy filtering: start held high and gx toggled during FILL; draw_done pulsed during FILL and KICK -> exactly one pass, data uses the originally latched gx; WAIT still requires a new draw_done.
- Timeout with TIMEOUT=100, draw_done never asserted -> done=1 and timeout_err=1 exactly 100 cycles after entering WAIT. The next start clears timeout_err in the acceptance cycle.
- Reset mid-FILL: rst_n low at cycle 20 -> field_we drops immediately; draw_start never fires. A new start after release produces a full 48-write pass from addr 0.
